// File: rtl/rank_border_ctrl_pkg.sv
// Shared types and helpers for the rank-transform border qualifier.
package rank_border_ctrl_pkg;

   // Geometry-tracking FSM states
   typedef enum logic [1:0] {
      StSearch  = 2'd0,
      StMeasure = 2'd1,
      StLocked  = 2'd2
   } rbc_state_e;

   // Halo of a square odd window: pixels on each side of the centre
   function automatic int unsigned halo(input int unsigned window_size);
      return (window_size - 1) / 2;
   endfunction

endpackage

// File: rtl/video_edge_detect.sv
// Rise/fall pulse generator for a bundle of video control signals.
// Pulses are formed from the current input and a registered previous sample, so they
// coincide with the first cycle that shows the new level.
module video_edge_detect #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sig,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   logic [WIDTH-1:0] prev_q;

   // Previous-cycle sample of every tracked signal
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else begin
         prev_q <= sig;
      end
   end

   // Edge pulses relative to the previous sample
   always_comb begin
      rise = sig & ~prev_q;
      fall = ~sig & prev_q;
   end

endmodule

// File: rtl/rank_border_ctrl.sv
// Border qualifier after the windowed rank transform: learns a stable frame size,
// then marks pixels whose window lies fully inside the image as valid and replaces
// the rest with a fixed border value. All outputs are registered (1-cycle latency).
module rank_border_ctrl
   import rank_border_ctrl_pkg::*;
#(
   parameter int unsigned WINDOW_SIZE  = 7,
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned ROW_WIDTH    = 10,
   parameter int unsigned COL_WIDTH    = 11,
   parameter int unsigned BORDER_VALUE = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  de_in,
   input  logic                  h_sync_in,
   input  logic                  v_sync_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  de_out,
   output logic                  h_sync_out,
   output logic                  v_sync_out,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  locked,
   output logic                  geom_err
);

   localparam int unsigned           Halo    = halo(WINDOW_SIZE);
   localparam logic [COL_WIDTH-1:0]  HaloCol = COL_WIDTH'(Halo);
   localparam logic [COL_WIDTH-1:0]  WinCol  = COL_WIDTH'(WINDOW_SIZE);
   localparam logic [ROW_WIDTH-1:0]  HaloRow = ROW_WIDTH'(Halo);
   localparam logic [ROW_WIDTH-1:0]  WinRow  = ROW_WIDTH'(WINDOW_SIZE);
   localparam logic [DATA_WIDTH-1:0] Border  = DATA_WIDTH'(BORDER_VALUE);

   // Edge pulses: bit 0 = de, bit 1 = v_sync
   logic [1:0] rise;
   logic [1:0] fall;
   logic       de_fall;
   logic       v_rise;
   logic       unused_edges;

   // Coordinate counters
   logic [ROW_WIDTH-1:0] row_q, row_d, row_inc;
   logic [COL_WIDTH-1:0] col_q, col_d;

   // Geometry: width_q doubles as the line width under measurement while in StMeasure
   logic [COL_WIDTH-1:0] width_q, width_d;
   logic [ROW_WIDTH-1:0] height_q, height_d;
   logic                 seen_q, seen_d;   // a line width has been captured this frame
   logic                 bad_q, bad_d;     // unequal line widths seen this frame
   logic                 armed_q, armed_d; // measurement frame started at a frame boundary

   logic [COL_WIDTH-1:0] meas_w;
   logic                 meas_bad;
   logic [ROW_WIDTH-1:0] height_now;

   rbc_state_e state_q, state_d;
   logic       geom_err_d;

   logic [ROW_WIDTH-1:0] cur_row;
   logic [COL_WIDTH-1:0] cur_col;
   logic                 valid_d;

   video_edge_detect #(
      .WIDTH(2)
   ) u_edge (
      .clk  (clk),
      .rst_n(rst_n),
      .sig  ({v_sync_in, de_in}),
      .rise (rise),
      .fall (fall)
   );

   assign de_fall      = fall[0];
   assign v_rise       = rise[1];
   assign unused_edges = rise[0] ^ fall[1];

   // Saturating row/col counters; the line end is applied before the frame clear
   always_comb begin
      row_inc = (row_q == '1) ? row_q : row_q + 1'b1;
      row_d   = row_q;
      col_d   = col_q;
      if (de_in) begin
         col_d = (col_q == '1) ? col_q : col_q + 1'b1;
      end
      if (de_fall) begin
         col_d = '0;
         row_d = row_inc;
      end
      if (v_rise) begin
         row_d = '0;
         col_d = de_in ? COL_WIDTH'(1) : '0;
      end
   end

   // Frame height as seen at this v_sync edge, counting a line that ends in the same cycle
   assign height_now = de_fall ? row_inc : row_q;

   // Width and consistency of the frame being measured, including a line ending now
   always_comb begin
      meas_w   = seen_q ? width_q : (de_fall ? col_q : '0);
      meas_bad = bad_q | (de_fall & seen_q & (col_q != width_q));
   end

   // Lock FSM: next state, geometry capture and mismatch detection
   always_comb begin
      state_d    = state_q;
      width_d    = width_q;
      height_d   = height_q;
      seen_d     = seen_q;
      bad_d      = bad_q;
      armed_d    = armed_q;
      geom_err_d = 1'b0;

      unique case (state_q)
         StSearch: begin
            if (v_rise) begin
               state_d = StMeasure;
               seen_d  = 1'b0;
               bad_d   = 1'b0;
               armed_d = 1'b1;
            end
         end

         StMeasure: begin
            if (de_fall && !seen_q) begin
               width_d = col_q;
               seen_d  = 1'b1;
            end else if (de_fall && (col_q != width_q)) begin
               bad_d = 1'b1;
            end
            if (v_rise) begin
               // Only a frame observed from its start may establish the lock
               if (armed_q && !meas_bad && (meas_w >= WinCol) && (height_now >= WinRow)) begin
                  state_d  = StLocked;
                  width_d  = meas_w;
                  height_d = height_now;
               end
               seen_d  = 1'b0;
               bad_d   = 1'b0;
               armed_d = 1'b1;
            end
         end

         StLocked: begin
            if (de_fall && (col_q != width_q)) begin
               geom_err_d = 1'b1;
               state_d    = StMeasure;
               seen_d     = 1'b0;
               bad_d      = 1'b0;
               // Rest of this frame is partial unless a new frame starts right now
               armed_d    = v_rise;
            end else if (v_rise && (height_now != height_q)) begin
               geom_err_d = 1'b1;
               state_d    = StMeasure;
               seen_d     = 1'b0;
               bad_d      = 1'b0;
               armed_d    = 1'b1;
            end
         end

         default: begin
            state_d = StSearch;
         end
      endcase

      if (!enable) begin
         state_d    = StSearch;
         geom_err_d = 1'b0;
      end
   end

   // Current pixel coordinates and window-inside-image qualification
   always_comb begin
      cur_row = v_rise ? '0 : row_q;
      cur_col = v_rise ? '0 : col_q;
      valid_d = enable && (state_q == StLocked) && de_in &&
                (cur_row >= HaloRow) && (cur_row < (height_q - HaloRow)) &&
                (cur_col >= HaloCol) && (cur_col < (width_q - HaloCol));
   end

   // Counters, geometry and FSM state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StSearch;
         row_q    <= '0;
         col_q    <= '0;
         width_q  <= '0;
         height_q <= '0;
         seen_q   <= 1'b0;
         bad_q    <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         row_q    <= row_d;
         col_q    <= col_d;
         width_q  <= width_d;
         height_q <= height_d;
         seen_q   <= seen_d;
         bad_q    <= bad_d;
         armed_q  <= armed_d;
      end
   end

   // Output register stage keeping syncs, data and qualifiers aligned
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         de_out     <= 1'b0;
         h_sync_out <= 1'b0;
         v_sync_out <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         geom_err   <= 1'b0;
      end else begin
         de_out     <= de_in;
         h_sync_out <= h_sync_in;
         v_sync_out <= v_sync_in;
         data_out   <= valid_d ? data_in : Border;
         valid_out  <= valid_d;
         geom_err   <= geom_err_d;
      end
   end

   assign locked = (state_q == StLocked);

endmodule
